// File: rtl/mw_writeback.sv
// Memory-to-writeback pipeline register with load extraction, GRF write-data mux
// and a retired-instruction counter.
module mw_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic        valid_3,
    input  logic [31:0] PC_3,
    input  logic [4:0]  A3_3,
    input  logic        RegWr_3,
    input  logic [1:0]  WDSel_3,
    input  logic [31:0] ALUOut_3,
    input  logic [31:0] DMRead_3,
    input  logic [2:0]  LdType_3,
    output logic [31:0] WPC,
    output logic [4:0]  A3_4,
    output logic        RegWr_4,
    output logic [31:0] WD_4,
    output logic [31:0] RetireCnt
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned LD_W   = 3;

    typedef enum logic [SEL_W-1:0] {
        WD_ALU  = 2'b00,
        WD_LOAD = 2'b01,
        WD_LINK = 2'b10,
        WD_ALU2 = 2'b11
    } wd_sel_e;

    typedef enum logic [LD_W-1:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] a3;
        logic              reg_wr;
        logic [SEL_W-1:0]  wd_sel;
        logic [XLEN-1:0]   alu_out;
        logic [XLEN-1:0]   dm_read;
        logic [LD_W-1:0]   ld_type;
    } w_entry_t;

    w_entry_t        entry_q, entry_d;
    logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;

    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wd;

    // Next-state: flush beats hold beats capture; the counter looks at the pre-edge entry.
    always_comb begin
        entry_d      = entry_q;
        retire_cnt_d = retire_cnt_q;
        if (entry_q.valid && !hold) begin
            retire_cnt_d = retire_cnt_q + XLEN'(1);
        end
        if (flush) begin
            entry_d = '0;
        end else if (!hold) begin
            entry_d.valid   = valid_3;
            entry_d.pc      = PC_3;
            entry_d.a3      = A3_3;
            entry_d.reg_wr  = RegWr_3;
            entry_d.wd_sel  = WDSel_3;
            entry_d.alu_out = ALUOut_3;
            entry_d.dm_read = DMRead_3;
            entry_d.ld_type = LdType_3;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_q      <= '0;
            retire_cnt_q <= '0;
        end else begin
            entry_q      <= entry_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Load extraction from the aligned word using the registered byte offset.
    always_comb begin
        ld_byte = 8'(entry_q.dm_read >> {entry_q.alu_out[1:0], 3'b000});
        ld_half = entry_q.alu_out[1] ? entry_q.dm_read[31:16] : entry_q.dm_read[15:0];
        ld_data = entry_q.dm_read;
        case (entry_q.ld_type)
            LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  ld_data = {24'h0, ld_byte};
            LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  ld_data = {16'h0, ld_half};
            default: ld_data = entry_q.dm_read;
        endcase
    end

    always_comb begin
        wd = entry_q.alu_out;
        case (entry_q.wd_sel)
            WD_LOAD: wd = ld_data;
            WD_LINK: wd = entry_q.pc + XLEN'(8);
            default: wd = entry_q.alu_out;
        endcase
    end

    // A held entry must not write, so the same write is never issued twice.
    assign RegWr_4   = entry_q.valid && entry_q.reg_wr && !hold && (entry_q.a3 != '0);
    assign WD_4      = wd;
    assign WPC       = entry_q.pc;
    assign A3_4      = entry_q.a3;
    assign RetireCnt = retire_cnt_q;

endmodule
